// File: rtl/game_controller.sv
// Tic-tac-toe game controller: move validation, win/draw detection and turn sequencing.
// Optional per-turn forfeit timer is compiled in when TURN_TIMEOUT_EN is defined.
module game_controller #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        moveValid,
   input  logic [3:0]  moveCell,
   output logic [17:0] board,
   output logic [1:0]  curPlayer,
   output logic [1:0]  state,
   output logic        moveAck,
   output logic        moveNack,
   output logic        Xwins,
   output logic        Owins,
   output logic        draw,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_MOVE = 2'b01,
      CHECK     = 2'b10,
      GAME_OVER = 2'b11
   } state_t;

   localparam logic [1:0] PLAYER_X   = 2'b10;
   localparam logic [1:0] PLAYER_O   = 2'b01;
   localparam logic [1:0] CELL_EMPTY = 2'b00;

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic [1:0]  cur_player_q, cur_player_d;
   logic [3:0]  move_cnt_q, move_cnt_d;
   logic        xwins_q, xwins_d;
   logic        owins_q, owins_d;
   logic        draw_q, draw_d;
   logic        move_ack_q, move_ack_d;
   logic        move_nack_q, move_nack_d;
   logic        timeout_q, timeout_d;

   logic [1:0]  cell_val;
   logic        move_ok;
   logic        x_line, o_line;

`ifdef TURN_TIMEOUT_EN
   logic [31:0] timer_q, timer_d;
`endif

   function automatic logic has_line(input logic [17:0] b, input logic [1:0] p);
      logic [8:0] m;
      for (int unsigned i = 0; i < 9; i++) m[i] = (b[2*i +: 2] == p);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   always_comb begin
      cell_val = CELL_EMPTY;
      for (int unsigned i = 0; i < 9; i++)
         if (moveCell == i[3:0]) cell_val = board_q[2*i +: 2];
   end

   assign move_ok = moveValid && (moveCell <= 4'd8) && (cell_val == CELL_EMPTY);
   assign x_line  = has_line(board_q, PLAYER_X);
   assign o_line  = has_line(board_q, PLAYER_O);

   always_comb begin
      state_d      = state_q;
      board_d      = board_q;
      cur_player_d = cur_player_q;
      move_cnt_d   = move_cnt_q;
      xwins_d      = xwins_q;
      owins_d      = owins_q;
      draw_d       = draw_q;
      move_ack_d   = 1'b0;
      move_nack_d  = 1'b0;
      timeout_d    = 1'b0;
`ifdef TURN_TIMEOUT_EN
      timer_d      = timer_q;
`endif
      case (state_q)
         IDLE, GAME_OVER: begin
            if (start) begin
               board_d      = '0;
               cur_player_d = PLAYER_X;
               move_cnt_d   = '0;
               xwins_d      = 1'b0;
               owins_d      = 1'b0;
               draw_d       = 1'b0;
               state_d      = WAIT_MOVE;
`ifdef TURN_TIMEOUT_EN
               timer_d      = '0;
`endif
            end
         end
         WAIT_MOVE: begin
            if (move_ok) begin
               for (int unsigned i = 0; i < 9; i++)
                  if (moveCell == i[3:0]) board_d[2*i +: 2] = cur_player_q;
               move_cnt_d = move_cnt_q + 4'd1;
               move_ack_d = 1'b1;
               state_d    = CHECK;
`ifdef TURN_TIMEOUT_EN
               timer_d    = '0;
`endif
            end else begin
               move_nack_d = moveValid;
`ifdef TURN_TIMEOUT_EN
               // a rejected request does not restart the turn timer
               if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
                  timeout_d    = 1'b1;
                  cur_player_d = (cur_player_q == PLAYER_X) ? PLAYER_O : PLAYER_X;
                  timer_d      = '0;
               end else begin
                  timer_d = timer_q + 32'd1;
               end
`endif
            end
         end
         CHECK: begin
            if (x_line) begin
               xwins_d = 1'b1;
               state_d = GAME_OVER;
            end else if (o_line) begin
               owins_d = 1'b1;
               state_d = GAME_OVER;
            end else if (move_cnt_q == 4'd9) begin
               draw_d  = 1'b1;
               state_d = GAME_OVER;
            end else begin
               cur_player_d = (cur_player_q == PLAYER_X) ? PLAYER_O : PLAYER_X;
               state_d      = WAIT_MOVE;
`ifdef TURN_TIMEOUT_EN
               timer_d      = '0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         board_q      <= '0;
         cur_player_q <= PLAYER_X;
         move_cnt_q   <= '0;
         xwins_q      <= 1'b0;
         owins_q      <= 1'b0;
         draw_q       <= 1'b0;
         move_ack_q   <= 1'b0;
         move_nack_q  <= 1'b0;
         timeout_q    <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         timer_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         board_q      <= board_d;
         cur_player_q <= cur_player_d;
         move_cnt_q   <= move_cnt_d;
         xwins_q      <= xwins_d;
         owins_q      <= owins_d;
         draw_q       <= draw_d;
         move_ack_q   <= move_ack_d;
         move_nack_q  <= move_nack_d;
         timeout_q    <= timeout_d;
`ifdef TURN_TIMEOUT_EN
         timer_q      <= timer_d;
`endif
      end
   end

   assign board     = board_q;
   assign curPlayer = cur_player_q;
   assign state     = state_q;
   assign moveAck   = move_ack_q;
   assign moveNack  = move_nack_q;
   assign Xwins     = xwins_q;
   assign Owins     = owins_q;
   assign draw      = draw_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: a rule-level tic-tac-toe model predicts each
// observable event (ack, nack, forfeit, game start, next turn, game over).
module tb_game_controller;

   localparam int unsigned TO = 8;
   localparam int EV_ACK = 0, EV_NACK = 1, EV_TMO = 2, EV_START = 3, EV_NEXT = 4, EV_OVER = 5;
   localparam int M_IDLE = 0, M_WAIT = 1, M_CHECK = 2, M_OVER = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        moveValid = 1'b0;
   logic [3:0]  moveCell = 4'd0;
   logic [17:0] board;
   logic [1:0]  curPlayer;
   logic [1:0]  state;
   logic        moveAck, moveNack, Xwins, Owins, draw, timeout;

   game_controller #(.TIMEOUT_CYCLES(32'(TO))) dut (
      .clk(clk), .reset(reset), .start(start), .moveValid(moveValid), .moveCell(moveCell),
      .board(board), .curPlayer(curPlayer), .state(state), .moveAck(moveAck),
      .moveNack(moveNack), .Xwins(Xwins), .Owins(Owins), .draw(draw), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [17:0] board;
      logic [1:0]  player;
      logic [1:0]  st;
      logic [2:0]  flags;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;

   // reference model: cells hold 0 empty, 1 O, 2 X; player 2 = X, 1 = O
   int          m_cells[9];
   int          m_player, m_count, m_state;
   logic [2:0]  m_flags;
`ifdef TURN_TIMEOUT_EN
   int unsigned m_timer;
`endif
   int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] model_board();
      logic [17:0] b = '0;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
      return b;
   endfunction

   function automatic int winner();
      for (int l = 0; l < 8; l++)
         if (m_cells[lines[l][0]] != 0 && m_cells[lines[l][0]] == m_cells[lines[l][1]] &&
             m_cells[lines[l][1]] == m_cells[lines[l][2]])
            return m_cells[lines[l][0]];
      return 0;
   endfunction

   function automatic void push(input int kind, input logic [1:0] st);
      exp_t e;
      e.kind = kind; e.board = model_board(); e.player = 2'(m_player);
      e.st = st; e.flags = m_flags;
      sbq.push_back(e);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 9; i++) m_cells[i] = 0;
      m_player = 2; m_count = 0; m_flags = 3'b000; m_state = M_IDLE;
`ifdef TURN_TIMEOUT_EN
      m_timer = 0;
`endif
   endfunction

   function automatic void model_edge(input logic s, input logic mv, input logic [3:0] c);
      int w;
      case (m_state)
         M_IDLE, M_OVER: begin
            if (s) begin
               for (int i = 0; i < 9; i++) m_cells[i] = 0;
               m_player = 2; m_count = 0; m_flags = 3'b000; m_state = M_WAIT;
`ifdef TURN_TIMEOUT_EN
               m_timer = 0;
`endif
               push(EV_START, 2'b01);
            end
         end
         M_WAIT: begin
            if (mv && c <= 4'd8 && m_cells[c] == 0) begin
               m_cells[c] = m_player; m_count++; m_state = M_CHECK;
`ifdef TURN_TIMEOUT_EN
               m_timer = 0;
`endif
               push(EV_ACK, 2'b10);
            end else begin
               if (mv) push(EV_NACK, 2'b01);
`ifdef TURN_TIMEOUT_EN
               if (m_timer == TO - 1) begin
                  m_player = 3 - m_player; m_timer = 0;
                  push(EV_TMO, 2'b01);
               end else m_timer++;
`endif
            end
         end
         M_CHECK: begin
            w = winner();
            if (w == 2)           begin m_flags = 3'b100; m_state = M_OVER; push(EV_OVER, 2'b11); end
            else if (w == 1)      begin m_flags = 3'b010; m_state = M_OVER; push(EV_OVER, 2'b11); end
            else if (m_count == 9) begin m_flags = 3'b001; m_state = M_OVER; push(EV_OVER, 2'b11); end
            else begin
               m_player = 3 - m_player; m_state = M_WAIT;
`ifdef TURN_TIMEOUT_EN
               m_timer = 0;
`endif
               push(EV_NEXT, 2'b01);
            end
         end
         default: ;
      endcase
   endfunction

   task automatic step(input logic s, input logic mv, input logic [3:0] c);
      @(negedge clk);
      reset = 1'b0; start = s; moveValid = mv; moveCell = c;
      model_edge(s, mv, c);
      @(posedge clk);
   endtask

   // reset asserted together with start and a move request: reset must win
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b1; moveValid = 1'b1; moveCell = 4'd0;
      model_reset();
      @(posedge clk); #2;
      check("rst_state", 32'(state), 32'd0);
      check("rst_board", 32'(board), 32'd0);
      check("rst_player", 32'(curPlayer), 32'h2);
      check("rst_flags", 32'({Xwins, Owins, draw}), 32'd0);
      check("rst_pulses", 32'({moveAck, moveNack, timeout}), 32'd0);
   endtask

   task automatic play(input int c);
      step(1'b0, 1'b1, 4'(c));
      step(1'b1, 1'b1, 4'd0);   // CHECK cycle: start and moveValid must be ignored
   endtask

   task automatic score(input int kind);
      exp_t e;
      if (sbq.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL sb_unexpected: event %0d seen, none expected at %0t", kind, $time);
      end else begin
         e = sbq.pop_front();
         check("sb_kind", 32'(kind), 32'(e.kind));
         check("sb_board", 32'(board), 32'(e.board));
         check("sb_player", 32'(curPlayer), 32'(e.player));
         check("sb_state", 32'(state), 32'(e.st));
         check("sb_flags", 32'({Xwins, Owins, draw}), 32'(e.flags));
      end
   endtask

   initial begin : monitor
      logic [1:0] prev_st;
      wait (mon_en);
      prev_st = state;
      forever begin
         @(posedge clk); #1;
         if (moveAck)  score(EV_ACK);
         if (moveNack) score(EV_NACK);
         if (timeout)  score(EV_TMO);
         if (state == 2'b01 && (prev_st == 2'b00 || prev_st == 2'b11)) score(EV_START);
         if (state == 2'b01 && prev_st == 2'b10) score(EV_NEXT);
         if (state == 2'b11 && prev_st != 2'b11) score(EV_OVER);
         check("flags_exclusive", 32'($countones({Xwins, Owins, draw}) <= 1), 32'd1);
         if (state != 2'b11) check("flags_outside_over", 32'({Xwins, Owins, draw}), 32'd0);
         prev_st = state;
      end
   end

   initial begin : driver
      logic       r_s, r_mv, r_rst;
      logic [3:0] r_c;
      logic [1:0] exp_cells [9];
      int         seq_win [5];
      int         seq_draw [9];

      do_reset();
      mon_en = 1'b1;

      // moves in IDLE are ignored
      step(1'b0, 1'b1, 4'd3);
      step(1'b0, 1'b1, 4'd4);

      // X takes the top row
      seq_win = '{0, 3, 1, 4, 2};
      step(1'b1, 1'b0, 4'd0);
      foreach (seq_win[i]) play(seq_win[i]);
      #2;
      check("win_xwins", 32'(Xwins), 32'd1);
      check("win_state", 32'(state), 32'h3);
      check("win_board", 32'(board), 32'h0016A);
      exp_cells = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 9; i++) check($sformatf("win_cell%0d", i), 32'(board[2*i +: 2]), 32'(exp_cells[i]));
      step(1'b0, 1'b1, 4'd7);   // ignored in GAME_OVER
      step(1'b0, 1'b0, 4'd0);
      #2 check("over_hold", 32'(board), 32'h0016A);

      // rejected requests: out-of-range and occupied cell
      step(1'b1, 1'b0, 4'd0);
      play(4);
      step(1'b0, 1'b1, 4'd9);
      step(1'b0, 1'b1, 4'd4);
      step(1'b0, 1'b1, 4'd15);
      #2;
      check("nack_board", 32'(board), 32'(18'h00200));
      check("nack_player", 32'(curPlayer), 32'h1);
      check("nack_state", 32'(state), 32'h1);

      // full board with no line
      do_reset();
      step(1'b1, 1'b0, 4'd0);
      seq_draw = '{4, 0, 2, 6, 3, 5, 7, 1, 8};
      foreach (seq_draw[i]) play(seq_draw[i]);
      #2;
      check("draw_flag", 32'(draw), 32'd1);
      check("draw_xo", 32'({Xwins, Owins}), 32'd0);
      check("draw_state", 32'(state), 32'h3);

      // reset while in CHECK after the third move
      step(1'b1, 1'b0, 4'd0);
      play(0);
      play(1);
      step(1'b0, 1'b1, 4'd2);
      do_reset();

      step(1'b1, 1'b0, 4'd0);
`ifdef TURN_TIMEOUT_EN
      for (int i = 0; i < int'(TO) - 1; i++) step(1'b0, 1'b0, 4'd0);
      #2 check("tmo_not_yet", 32'(timeout), 32'd0);
      step(1'b0, 1'b0, 4'd0);
      #2;
      check("tmo_pulse", 32'(timeout), 32'd1);
      check("tmo_player", 32'(curPlayer), 32'h1);
      for (int i = 0; i < int'(TO) - 1; i++) step(1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b1, 4'd4);
      #2;
      check("tmo_edge_ack", 32'(moveAck), 32'd1);
      check("tmo_edge_none", 32'(timeout), 32'd0);
      step(1'b0, 1'b0, 4'd0);
`else
      for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 4'd0);
      #2;
      check("wait_state", 32'(state), 32'h1);
      check("wait_player", 32'(curPlayer), 32'h2);
      check("wait_timeout", 32'(timeout), 32'd0);
`endif

      // randomized games
      for (int g = 0; g < 40; g++) begin
         step(1'b1, 1'b0, 4'd0);
         for (int cyc = 0; cyc < 200 && m_state != M_OVER; cyc++) begin
            r_rst = ($urandom_range(0, 150) == 0);
            if (r_rst) begin
               do_reset();
               break;
            end
            r_s  = ($urandom_range(0, 9) == 0);
            r_mv = ($urandom_range(0, 3) != 0);
            r_c  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            step(r_s, r_mv, r_c);
         end
      end

      step(1'b0, 1'b0, 4'd0);
      step(1'b0, 1'b0, 4'd0);
      #2 check("sb_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
